// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller and the fetch/decode side.
// FSM encodings, config map helpers, mask reset value and special opcodes.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ENTER   = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  localparam int ID_W = 3;

  // Mask bit 1 = source disabled; everything starts disabled.
  localparam logic [7:0] MASK_RST = 8'hFF;

  // Opcodes decoded by fetch/decode; RETI is what ends a handler.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_RETI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // The mask register sits immediately after the vector table.
  function automatic int cfg_mask_addr(input int n_src);
    return n_src;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set index of eligible_i wins.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] eligible_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             valid_o
);

  // Walk downward so the lowest eligible index is the last one assigned.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        winner_o = i[ID_W-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, fixed priority and the
// fetch/decode handshake (ARMED -> ENTER -> SERVICE until reti).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int PC_W   = 10,
  parameter int CFG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [PC_W-1:0]   cfg_wdata,
  output logic [PC_W-1:0]   cfg_rdata,
  input  logic              available_for_int,
  output logic              int_occured,
  output logic [PC_W-1:0]   int_pc,
  output logic [ID_W-1:0]   active_id,
  output logic              in_service,
  output logic [N_SRC-1:0]  pending
);

  localparam logic [CFG_AW-1:0] MASK_ADDR = CFG_AW'(cfg_mask_addr(N_SRC));

  state_e                        state_q;
  logic [N_SRC-1:0]              irq_prev_q;
  logic [N_SRC-1:0]              pending_q, pending_d;
  logic [N_SRC-1:0]              mask_q;
  logic [N_SRC-1:0][PC_W-1:0]    vec_q;
  logic [ID_W-1:0]               active_id_q;
  logic [PC_W-1:0]               int_pc_q;
  logic                          in_service_q;

  logic [N_SRC-1:0] irq_rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] act_oh;
  logic [ID_W-1:0]  winner;
  logic             win_vld;
  logic [PC_W-1:0]  win_pc;

  assign irq_rise = irq_in & ~irq_prev_q;
  assign eligible = pending_q & ~mask_q;

  int_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .eligible_i (eligible),
    .winner_o   (winner),
    .valid_o    (win_vld)
  );

  always_comb begin
    act_oh = '0;
    win_pc = '0;
    for (int i = 0; i < N_SRC; i++) begin
      act_oh[i] = (active_id_q == i[ID_W-1:0]);
      if (winner == i[ID_W-1:0]) win_pc = vec_q[i];
    end
  end

  // Request is combinational from state so the CPU sees it the cycle it frees up.
  assign int_occured = (state_q == ST_ARMED) && available_for_int && !rst;

  // A new edge re-sets a bit in the same cycle it would be cleared.
  always_comb begin
    pending_d = pending_q;
    if (state_q == ST_ARMED && available_for_int) pending_d = pending_d & ~act_oh;
    if (state_q == ST_ENTER && available_for_int) pending_d = pending_d | act_oh;
    pending_d = pending_d | irq_rise;
  end

  always_ff @(posedge clk) begin
    irq_prev_q <= irq_in;
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= MASK_RST[N_SRC-1:0];
      vec_q  <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cfg_addr == CFG_AW'(i)) vec_q[i] <= cfg_wdata;
      end
      if (cfg_addr == MASK_ADDR) mask_q <= cfg_wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cfg_addr == CFG_AW'(i)) cfg_rdata = vec_q[i];
    end
    if (cfg_addr == MASK_ADDR) cfg_rdata = PC_W'(mask_q);
  end

  // Once ARMED the winner and its vector are frozen until the block returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      active_id_q  <= '0;
      int_pc_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q     <= ST_ARMED;
            active_id_q <= winner;
            int_pc_q    <= win_pc;
          end
        end
        ST_ARMED: begin
          if (available_for_int) state_q <= ST_ENTER;
        end
        ST_ENTER: begin
          if (available_for_int) begin
            state_q <= ST_IDLE;
          end else begin
            state_q      <= ST_SERVICE;
            in_service_q <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (available_for_int) begin
            state_q      <= ST_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign int_pc     = int_pc_q;
  assign active_id  = active_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus random traffic, every cycle
// checked against a phase-level reference model of the interrupt protocol.
module tb_int_ctrl;

  localparam int N  = 4;
  localparam int PW = 10;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [PW-1:0] cfg_wdata;
  logic [PW-1:0] cfg_rdata;
  logic          avail;
  logic          int_occured;
  logic [PW-1:0] int_pc;
  logic [2:0]    active_id;
  logic          in_service;
  logic [N-1:0]  pending;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  int_ctrl #(.N_SRC(N), .PC_W(PW), .CFG_AW(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .irq_in            (irq_in),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_wdata         (cfg_wdata),
    .cfg_rdata         (cfg_rdata),
    .available_for_int (avail),
    .int_occured       (int_occured),
    .int_pc            (int_pc),
    .active_id         (active_id),
    .in_service        (in_service),
    .pending           (pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Protocol phases: waiting, offering to CPU, CPU just taken it, handler running.
  typedef enum {PH_IDLE, PH_OFFER, PH_TAKEN, PH_HANDLER} ph_t;
  ph_t           m_ph;
  bit  [N-1:0]   m_pend, m_mask, m_prev;
  bit  [PW-1:0]  m_vec [N];
  bit  [PW-1:0]  m_pc;
  int            m_id;

  function automatic bit [PW-1:0] m_rdata(input int a);
    if (a < N)  return m_vec[a];
    if (a == N) return PW'(m_mask);
    return '0;
  endfunction

  task automatic model_step();
    bit [N-1:0] rise, elig;
    int w;
    if (rst) begin
      m_ph = PH_IDLE; m_pend = '0; m_mask = '1; m_pc = '0; m_id = 0;
      for (int i = 0; i < N; i++) m_vec[i] = '0;
      m_prev = irq_in;
      return;
    end
    rise = irq_in & ~m_prev;
    case (m_ph)
      PH_IDLE: begin
        elig = m_pend & ~m_mask;
        w = -1;
        for (int i = 0; i < N; i++) if (elig[i] && w < 0) w = i;
        if (w >= 0) begin m_ph = PH_OFFER; m_id = w; m_pc = m_vec[w]; end
      end
      PH_OFFER:   if (avail) begin m_pend[m_id] = 1'b0; m_ph = PH_TAKEN; end
      PH_TAKEN:   if (avail) begin m_pend[m_id] = 1'b1; m_ph = PH_IDLE; end
                  else m_ph = PH_HANDLER;
      PH_HANDLER: if (avail) m_ph = PH_IDLE;
      default:    m_ph = PH_IDLE;
    endcase
    m_pend |= rise;
    if (cfg_we) begin
      if (int'(cfg_addr) < N) m_vec[cfg_addr] = cfg_wdata;
      else if (int'(cfg_addr) == N) m_mask = cfg_wdata[N-1:0];
    end
    m_prev = irq_in;
  endtask

  // Inputs are set at the falling edge; compare shortly after, then advance.
  task automatic tick();
    #1;
    chk("occured", int_occured, (m_ph == PH_OFFER) && avail && !rst);
    chk("pending", pending, m_pend);
    chk("in_service", in_service, m_ph == PH_HANDLER);
    chk("active_id", active_id, m_id);
    chk("int_pc", int_pc, m_pc);
    chk("cfg_rdata", cfg_rdata, m_rdata(int'(cfg_addr)));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cfg_wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = PW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; avail = 1'b1;
    m_ph = PH_IDLE; m_pend = '0; m_mask = '1; m_prev = '0; m_pc = '0; m_id = 0;
    for (int i = 0; i < N; i++) m_vec[i] = '0;
    @(negedge clk);
    ticks(2);
    cfg_addr = AW'(N);
    #1 chk("rst_mask", cfg_rdata, 10'h00F);
    chk("rst_pending", pending, 4'h0);
    rst = 1'b0;

    // Basic handshake
    cfg_wr(1, 'h120);
    cfg_wr(N, 'b1101);
    irq_in = 4'b0010; tick();
    irq_in = 4'b0000; tick();
    #1 chk("hs_occ", int_occured, 1'b1);
    chk("hs_pc", int_pc, 10'h120);
    chk("hs_id", active_id, 3'd1);
    tick();
    avail = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      #1 chk("hs_svc", in_service, 1'b1);
      tick();
    end
    avail = 1'b1; ticks(2);
    #1 chk("hs_done_pend", pending, 4'h0);
    chk("hs_done_svc", in_service, 1'b0);

    // Priority: sources 0 and 3 together
    cfg_wr(0, 'h040); cfg_wr(3, 'h3C0); cfg_wr(N, 0);
    irq_in = 4'b1001; tick();
    irq_in = 4'b0000; tick();
    #1 chk("prio_id", active_id, 3'd0);
    chk("prio_pc", int_pc, 10'h040);
    tick();
    avail = 1'b0; ticks(3);
    avail = 1'b1; ticks(6);

    // Masked source latches but does not issue until unmasked
    cfg_wr(N, 'b0100);
    irq_in = 4'b0100; tick();
    irq_in = 4'b0000; ticks(4);
    #1 chk("mask_pend", pending[2], 1'b1);
    chk("mask_noint", int_occured, 1'b0);
    cfg_wr(N, 0);
    tick();
    #1 chk("unmask_occ", int_occured, 1'b1);
    ticks(3);

    // Busy CPU holds the request in ARMED
    irq_in = 4'b0001; avail = 1'b0; tick();
    irq_in = 4'b0000; ticks(11);
    avail = 1'b1; tick();
    avail = 1'b0; ticks(3);
    avail = 1'b1; ticks(3);

    // Lost request: CPU stays available through ENTER, then re-issue
    irq_in = 4'b0010; tick();
    irq_in = 4'b0000; ticks(6);
    avail = 1'b0; ticks(3);
    avail = 1'b1; ticks(3);

    // Reset in the middle of a handler with irq 0 held high
    irq_in = 4'b0001; tick(); tick(); tick();
    avail = 1'b0; ticks(3);
    rst = 1'b1; ticks(2);
    rst = 1'b0; avail = 1'b1;
    cfg_wr(N, 0);
    ticks(8);
    #1 chk("rst_hold_noint", int_occured, 1'b0);
    irq_in = 4'b0000; ticks(2);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) irq_in[i] = ~irq_in[i];
      avail  = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 11) == 0);
      cfg_addr  = AW'($urandom_range(0, 15));
      cfg_wdata = PW'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller for the pipelined CPU. It collects N_SRC external interrupt lines, latches them as pending, masks them, and selects one by fixed priority.
- It drives the fetch/decode interrupt handshake: it checks available_for_int, presents int_pc, and pulses int_occured for one cycle.
- It then tracks the handler until reti returns the CPU to normal execution. Nesting is not supported.

Parameters:
- N_SRC, 4, number of interrupt sources; valid range 1..8.
- PC_W, 10, width of handler PC and vector entries; matches the instruction RAM address width.
- CFG_AW, 4, config address width; must satisfy 2^CFG_AW > N_SRC.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- irq_in  in  N_SRC  raw interrupt lines, rising-edge sensitive, synchronous to clk.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  CFG_AW  config address: 0..N_SRC-1 select a vector entry; N_SRC selects the mask register.
- cfg_wdata  in  PC_W  config write data; only bits [N_SRC-1:0] are used for the mask.
- cfg_rdata  out  PC_W  combinational readback of the addressed register; 0 for unmapped addresses.
- available_for_int  in  1  from fetch/decode; 1 = CPU can accept an interrupt this cycle.
- int_occured  out  1  one-cycle request to fetch/decode.
- int_pc  out  PC_W  handler PC; valid whenever state is not IDLE.
- active_id  out  3  index of the source being issued or serviced.
- in_service  out  1  1 while a handler is executing.
- pending  out  N_SRC  latched pending bits, before masking.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, pending=0, mask=all 1s (all sources disabled), vectors=0.
  - int_pc=0, active_id=0, in_service=0.
  - irq_prev<=irq_in, so a line already high at reset release is not treated as an edge.
  - int_occured=0 throughout reset.
  - Reset mid-service abandons tracking; the CPU-side state is not restored by this block.
- Edge detect: pending[i] sets at the posedge where irq_in[i]=1 and irq_prev[i]=0.
  - If a set and a clear of pending[i] occur in the same cycle, the set wins.
- Mask: mask bit 1 = disabled. Masked sources still latch pending; they are only excluded from selection.
- Selection: eligible = pending & ~mask. The lowest eligible index wins (fixed priority).
- FSM states: IDLE, ARMED, ENTER, SERVICE.
  - IDLE: if eligible != 0, go to ARMED at the next edge. On that edge, latch active_id=winner and int_pc=vector[winner].
  - ARMED: int_occured = available_for_int (combinational from state). When int_occured=1, clear pending[active_id] and go to ENTER. Otherwise stay in ARMED indefinitely.
    - Once ARMED, the choice is committed. Later mask or vector writes, or higher-priority edges, do not change active_id or int_pc.
  - ENTER (one cycle): if available_for_int=0, the CPU took the interrupt: go to SERVICE. If it is 1, the request was lost: re-set pending[active_id] and go to IDLE.
  - SERVICE: in_service=1. When available_for_int returns to 1 (reti completed), go to IDLE. A halted CPU keeps the block in SERVICE.
- int_occured is never high for two consecutive cycles, and never high outside ARMED.
- Latency: a rising irq sampled at edge k (CPU available, source unmasked) gives int_occured=1 in the cycle after edge k+1. Best-case back-to-back interrupt: IDLE one cycle after reti.
- New edges during ARMED, ENTER or SERVICE only latch pending.
- Config writes take effect at the next edge, including in IDLE; selection in that cycle uses the old values.
- Writes to unmapped addresses are ignored.

Decomposition:
- Shared defines include file (int_ctrl_defs.vh):
  - FSM state encodings for IDLE, ARMED, ENTER and SERVICE.
  - CFG_MASK_ADDR = N_SRC.
  - Mask reset value.
  - Special opcodes (NOP/HALT/RETI), shared with fetch/decode.
- One sub-module, int_prio_enc: combinational, N_SRC-bit eligible in; winner index and valid out.

Test Plan:
- Basic handshake: after reset, write vector[1]=0x120 and mask=4'b1101, hold available=1, pulse irq_in[1] at edge 3 → int_occured=1 in the cycle after edge 4 only; int_pc=0x120; active_id=1. Then drive available=0 for 5 cycles, then 1 → in_service=1 for those 5 cycles, then IDLE and pending=0.
- Priority: mask=0, edges on irq 3 and 0 in the same cycle → source 0 is issued first (vector[0]). Source 3 stays pending and issues after the first service ends.
- Masked source: mask[2]=1, edge on irq 2 → pending[2]=1 and no int_occured. Clear mask[2] → issue 2 cycles later.
- Busy CPU: ARMED with available=0 for 10 cycles → int_occured stays 0. It pulses exactly one cycle when available rises.
- Lost request: in ENTER, force available=1 → pending re-set, return to IDLE, re-issue.
- Reset mid-SERVICE with irq_in[0] held high → all outputs reset values; no interrupt issued after release until a new rising edge.
